grey_to_binary: RTL and testbench
=================================

// Module: grey_to_binary
// PURPOSE
//  Registered 4-bit Gray-code to binary converter with a single-bit-step checker.
//  Accepts one reflected-Gray word per clock when in_valid is high.
//  Presents the binary equivalent one cycle later, with out_valid.
//  Sits after Gray-coded counters/encoders (e.g. CDC pointers, rotary encoders)
//  and feeds binary consumers.
//  Flags any input sequence that violates the Gray one-bit-change rule.
// PARAMETERS
//  CHECK_STEP  1  1 = step checker enabled; 0 = step_err tied 0, history logic removed
// PORTS
//  clk       input   1  single clock, all state updates on rising edge
//  rst_n     input   1  synchronous, active-low reset (sampled on clk rising edge)
//  in_valid  input   1  g1..g4 hold a valid Gray word this cycle
//  g1        input   1  Gray bit 3 (MSB)
//  g2        input   1  Gray bit 2
//  g3        input   1  Gray bit 1
//  g4        input   1  Gray bit 0 (LSB)
//  out_valid output  1  b1..b4 and step_err valid this cycle
//  b1        output  1  binary bit 3 (MSB)
//  b2        output  1  binary bit 2
//  b3        output  1  binary bit 1
//  b4        output  1  binary bit 0 (LSB)
//  step_err  output  1  current word differs from previous valid word in >1 bit
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   - b1..b4=0, out_valid=0, step_err=0.
//   - History register cleared; history-valid flag cleared.
//   - Reset overrides in_valid in the same cycle; an in-flight word is discarded.
//  Conversion (combinational, then registered):
//   - b1=g1; b2=g1^g2; b3=g1^g2^g3; b4=g1^g2^g3^g4 (prefix XOR from MSB).
//  Latency: exactly 1 cycle.
//   - Word sampled at edge N with in_valid=1 appears on b1..b4 after edge N,
//     with out_valid=1 for that one cycle.
//  in_valid=0:
//   - out_valid=0 next cycle.
//   - b1..b4 and step_err HOLD their last values.
//   - History unchanged.
//  No backpressure; a new word may be accepted every cycle.
//  Step checker (CHECK_STEP=1):
//   - Compares accepted Gray word against the previous accepted Gray word.
//   - step_err=1 if popcount(XOR) > 1.
//   - Identical words (0 bits changed) are legal: step_err=0.
//   - First valid word after reset has no history: step_err=0.
//   - Wrap 1000->0000 is a one-bit change: legal.
//   - step_err is registered with b1..b4 (same cycle as out_valid).
//   - History then updates to the current word, even when an error is flagged.
//  No X propagation from outputs after reset; all outputs are fully registered.
// TESTING
//  1. Reset, then in_valid pulse with g=0000 -> next cycle b=0000, out_valid=1, step_err=0.
//  2. Full 16-word Gray sweep 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,
//     1111,1110,1010,1011,1001,1000, one per cycle:
//     -> b=0..15 ascending (e.g. 0110->0100, 1100->1000, 1000->1111),
//        step_err=0 throughout.
//  3. Valid 0000 then valid 0011 -> second output b=0010, step_err=1;
//     then valid 0010 -> step_err=0 (history = 0011).
//  4. in_valid gaps: word 0101, idle 3 cycles, word 0100
//     -> b holds 0110 with out_valid=0 during gap; then b=0111, step_err=0.
//  5. rst_n=0 asserted together with in_valid=1, g=1111 -> next cycle all outputs 0;
//     first word after reset g=1010 -> b=1100, step_err=0.
//  6. CHECK_STEP=0: repeat scenario 3 -> step_err stays 0, b values identical.

Source files
------------

// File: rtl/grey_to_binary.sv
// Registered 4-bit reflected-Gray to binary converter with a one-bit-step checker.
// Output word, valid strobe and step error are registered together, one cycle after acceptance.
module grey_to_binary #(
    parameter bit CHECK_STEP = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic g1,
    input  logic g2,
    input  logic g3,
    input  logic g4,
    output logic out_valid,
    output logic b1,
    output logic b2,
    output logic b3,
    output logic b4,
    output logic step_err
);

    // Prefix XOR from the MSB down.
    function automatic logic [3:0] gray_to_bin(input logic [3:0] gray);
        logic [3:0] bin;
        bin[3] = gray[3];
        bin[2] = bin[3] ^ gray[2];
        bin[1] = bin[2] ^ gray[1];
        bin[0] = bin[1] ^ gray[0];
        return bin;
    endfunction

    // True when more than one bit differs: clearing the lowest set bit leaves something.
    function automatic logic multi_bit_change(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] diff;
        diff = a ^ b;
        return ((diff & (diff - 4'd1)) != 4'd0);
    endfunction

    logic [3:0] gray_s;
    logic [3:0] bin_s;
    logic       step_err_s;

    logic       out_valid_r;
    logic [3:0] bin_r;
    logic       step_err_r;

    assign gray_s = {g1, g2, g3, g4};
    assign bin_s  = gray_to_bin(gray_s);

    if (CHECK_STEP) begin : g_step
        logic [3:0] hist_r;
        logic       hist_valid_r;

        // Remember the last accepted Gray word, even when it was flagged as a bad step.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                hist_r       <= 4'd0;
                hist_valid_r <= 1'b0;
            end else if (in_valid) begin
                hist_r       <= gray_s;
                hist_valid_r <= 1'b1;
            end else begin
                hist_r       <= hist_r;
                hist_valid_r <= hist_valid_r;
            end
        end

        // The first word after reset has nothing to compare against.
        always_comb begin
            step_err_s = 1'b0;
            if (hist_valid_r) begin
                step_err_s = multi_bit_change(hist_r, gray_s);
            end else begin
                step_err_s = 1'b0;
            end
        end
    end else begin : g_no_step
        assign step_err_s = 1'b0;
    end

    // Output stage: capture on acceptance, otherwise hold word and error, drop valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            bin_r       <= 4'd0;
            step_err_r  <= 1'b0;
        end else if (in_valid) begin
            out_valid_r <= 1'b1;
            bin_r       <= bin_s;
            step_err_r  <= step_err_s;
        end else begin
            out_valid_r <= 1'b0;
            bin_r       <= bin_r;
            step_err_r  <= step_err_r;
        end
    end

    assign out_valid = out_valid_r;
    assign b1        = bin_r[3];
    assign b2        = bin_r[2];
    assign b3        = bin_r[1];
    assign b4        = bin_r[0];
    assign step_err  = step_err_r;

endmodule

// File: tb/tb_grey_to_binary.sv
// Scoreboard bench for grey_to_binary: checker-enabled and checker-disabled
// instances share stimulus; a monitor compares every cycle against a queue of expectations.
module tb_grey_to_binary;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid;
    logic [3:0] g;

    wire        ov_a, ov_b;
    wire  [3:0] bo_a, bo_b;
    wire        err_a, err_b;

    grey_to_binary #(.CHECK_STEP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .g1(g[3]), .g2(g[2]), .g3(g[1]), .g4(g[0]),
        .out_valid(ov_a),
        .b1(bo_a[3]), .b2(bo_a[2]), .b3(bo_a[1]), .b4(bo_a[0]),
        .step_err(err_a)
    );

    grey_to_binary #(.CHECK_STEP(1'b0)) dut_nochk (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .g1(g[3]), .g2(g[2]), .g3(g[1]), .g4(g[0]),
        .out_valid(ov_b),
        .b1(bo_b[3]), .b2(bo_b[2]), .b3(bo_b[1]), .b4(bo_b[0]),
        .step_err(err_b)
    );

    typedef struct {
        int         due;
        logic [3:0] b;
        logic       err;
    } exp_t;

    exp_t q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int reset_due = -1;
    bit mon_en   = 1'b0;

    // reference model state (stimulus side)
    logic [3:0] prev;
    bit         has_hist;

    // values the outputs must hold while out_valid is low
    logic [3:0] last_b;
    logic       last_err;

    always @(posedge clk) cyc <= cyc + 1;

    // Binary value = position of the word in the reflected-Gray sequence.
    function automatic logic [3:0] gray_index(input logic [3:0] w);
        for (int i = 0; i < 16; i++) begin
            if (4'(i ^ (i >> 1)) == w) return 4'(i);
        end
        return 4'd0;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [3:0] w);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = v;
        g        = w;
        if (v) begin
            e.due = cyc + 1;
            e.b   = gray_index(w);
            e.err = has_hist && ($countones(w ^ prev) > 1);
            q.push_back(e);
            prev     = w;
            has_hist = 1'b1;
        end
    endtask

    task automatic do_reset(input bit v, input logic [3:0] w);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        in_valid  = v;
        g         = w;
        has_hist  = 1'b0;
        reset_due = cyc + 1;
    endtask

    // Monitor: reset cycle, scheduled output, or hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].due < cyc) begin
                chk("stale_expectation", 4'd1, 4'd0);
                void'(q.pop_front());
            end
            if (cyc == reset_due) begin
                chk("rst_valid", {3'b000, ov_a}, 4'd0);
                chk("rst_b", bo_a, 4'd0);
                chk("rst_err", {3'b000, err_a}, 4'd0);
                chk("rst_valid_nochk", {3'b000, ov_b}, 4'd0);
                chk("rst_b_nochk", bo_b, 4'd0);
                last_b   = 4'd0;
                last_err = 1'b0;
            end else if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("valid", {3'b000, ov_a}, 4'd1);
                chk("bin", bo_a, e.b);
                chk("step_err", {3'b000, err_a}, {3'b000, e.err});
                chk("valid_nochk", {3'b000, ov_b}, 4'd1);
                chk("bin_nochk", bo_b, e.b);
                chk("step_err_nochk", {3'b000, err_b}, 4'd0);
                last_b   = e.b;
                last_err = e.err;
            end else begin
                chk("idle_valid", {3'b000, ov_a}, 4'd0);
                chk("hold_bin", bo_a, last_b);
                chk("hold_err", {3'b000, err_a}, {3'b000, last_err});
                chk("idle_valid_nochk", {3'b000, ov_b}, 4'd0);
                chk("hold_bin_nochk", bo_b, last_b);
                chk("hold_err_nochk", {3'b000, err_b}, 4'd0);
            end
        end
    end

    logic [3:0] sweep [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                               4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000};

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        g        = 4'd0;
        has_hist = 1'b0;
        prev     = 4'd0;
        last_b   = 4'd0;
        last_err = 1'b0;
        do_reset(1'b0, 4'd0);
        mon_en = 1'b1;
        do_reset(1'b0, 4'd0);

        // single word
        drive(1'b1, 4'b0000);
        drive(1'b0, 4'b0000);

        // full sweep
        do_reset(1'b0, 4'd0);
        for (int i = 0; i < 16; i++) drive(1'b1, sweep[i]);
        drive(1'b1, 4'b0000);

        // two-bit jump, then a legal step from the bad word
        do_reset(1'b0, 4'd0);
        drive(1'b1, 4'b0000);
        drive(1'b1, 4'b0011);
        drive(1'b1, 4'b0010);
        drive(1'b1, 4'b0010);

        // gaps hold the output
        drive(1'b1, 4'b0101);
        for (int i = 0; i < 3; i++) drive(1'b0, 4'($urandom_range(0, 15)));
        drive(1'b1, 4'b0100);
        drive(1'b0, 4'b1111);

        // reset overrides a simultaneous word
        do_reset(1'b1, 4'b1111);
        drive(1'b1, 4'b1010);
        drive(1'b0, 4'd0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_reset(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            end else if (r < 25) begin
                drive(1'b0, 4'($urandom_range(0, 15)));
            end else if (r < 70) begin
                int k;
                k = $urandom_range(0, 4);
                if (k == 4) drive(1'b1, prev);
                else        drive(1'b1, prev ^ 4'(4'd1 << k));
            end else begin
                drive(1'b1, 4'($urandom_range(0, 15)));
            end
        end

        drive(1'b0, 4'd0);
        drive(1'b0, 4'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", 4'(q.size()), 4'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
